// File: rtl/data_bus_sram_slave.sv
// data_bus_sram_slave: CPU data-bus responder sequencing an asynchronous SRAM.
// Accepts one read or write at a time and stalls the master while the SRAM
// control pins are walked through the access. bus_rdata holds the last read.
// Optional build macro DATA_BUS_POSTED_WRITE_EN: writes retire to the master on
// acceptance and the SRAM write runs in the background from a one-entry buffer.
module data_bus_sram_slave #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned WAIT_CYCLES = 1    // extra access cycles, 0..15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  bus_read,
  input  logic                  bus_write,
  input  logic [31:0]           bus_address,
  input  logic [3:0]            bus_mask,
  input  logic [31:0]           bus_wdata,
  output logic [31:0]           bus_rdata,
  output logic                  bus_stall,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_data_o,
  input  logic [31:0]           sram_data_i,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [3:0]            sram_be_n
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWsetup,
    StWpulse,
    StWhold,
    StDone
  } state_e;

  // Same counter paces both the read strobe and the write pulse.
  localparam logic [3:0] WaitLoad = WAIT_CYCLES[3:0];

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            be_n_q, be_n_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;

  logic ce_n_q, ce_n_d;
  logic oe_n_q, oe_n_d;
  logic we_n_q, we_n_d;
  logic data_oe_q, data_oe_d;

  logic accept_wr, accept_rd;

  // Write wins when both strobes are presented together.
  assign accept_wr = (state_q == StIdle) && bus_write;
  assign accept_rd = (state_q == StIdle) && bus_read && !bus_write;

  // Next-state, counter and request latching.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_n_d  = be_n_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (accept_wr || accept_rd) begin
          addr_d  = bus_address[ADDR_WIDTH+1:2];
          be_n_d  = ~bus_mask;
          wdata_d = bus_wdata;
          cnt_d   = WaitLoad;
          state_d = accept_wr ? StWsetup : StRead;
        end
      end
      StRead: begin
        if (cnt_q == 4'd0) begin
          rdata_d = sram_data_i;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWsetup: begin
        state_d = StWpulse;
      end
      StWpulse: begin
        if (cnt_q == 4'd0) begin
          state_d = StWhold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWhold: begin
        state_d = StDone;
      end
      StDone: begin
        // A request seen here is deliberately not taken; IDLE picks it up next cycle.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // SRAM pin decode from the next state, so the pins come straight off flops.
  always_comb begin
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    data_oe_d = 1'b0;
    unique case (state_d)
      StRead: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      StWsetup, StWhold: begin
        ce_n_d    = 1'b0;
        data_oe_d = 1'b1;
      end
      StWpulse: begin
        ce_n_d    = 1'b0;
        we_n_d    = 1'b0;
        data_oe_d = 1'b1;
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  // Sequencer state and latched request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_n_q  <= 4'hF;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_n_q  <= be_n_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM control pins; async reset drops them inactive mid-access.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
    end else begin
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      data_oe_q <= data_oe_d;
    end
  end

`ifdef DATA_BUS_POSTED_WRITE_EN
  logic last_wr_q;

  // Remembers whether the access in flight is a posted write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_wr_q <= 1'b0;
    end else if (accept_wr || accept_rd) begin
      last_wr_q <= accept_wr;
    end
  end

  // Writes retire on acceptance; anything arriving behind a buffered write waits.
  always_comb begin
    bus_stall = 1'b0;
    unique case (state_q)
      StIdle:  bus_stall = bus_read && !bus_write;
      StRead:  bus_stall = 1'b1;
      StDone:  bus_stall = last_wr_q && (bus_read || bus_write);
      default: bus_stall = bus_read || bus_write;
    endcase
  end
`else
  // Stall from acceptance until the access reaches DONE.
  always_comb begin
    bus_stall = ((state_q == StIdle) && (bus_read || bus_write)) ||
                !(state_q inside {StIdle, StDone});
  end
`endif

  assign bus_rdata    = rdata_q;
  assign sram_addr    = addr_q;
  assign sram_be_n    = be_n_q;
  assign sram_data_o  = wdata_q;
  assign sram_data_oe = data_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;

  // Byte-offset and out-of-range address bits carry no meaning here.
  if (ADDR_WIDTH < 30) begin : g_unused_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus_address[31:ADDR_WIDTH+2];
  end
  logic unused_addr_lo;
  assign unused_addr_lo = ^bus_address[1:0];

  // Never drive the data pins while the SRAM outputs are enabled.
  a_no_contention: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    !(sram_data_oe && !sram_oe_n));
  a_we_oe_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 !(!sram_we_n && !sram_oe_n));

endmodule

// File: tb/tb_data_bus_sram_slave.sv
// Scoreboard bench for data_bus_sram_slave with a behavioural async SRAM.
module tb_data_bus_sram_slave;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_read, bus_write;
  logic [31:0] bus_address, bus_wdata, bus_rdata;
  logic [3:0]  bus_mask;
  logic        bus_stall;
  logic [19:0] sram_addr;
  logic [31:0] sram_data_o, sram_data_i;
  logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;

  always #5 clk = ~clk;

  data_bus_sram_slave #(
    .ADDR_WIDTH (20),
    .WAIT_CYCLES(W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .bus_address (bus_address),
    .bus_mask    (bus_mask),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .bus_stall   (bus_stall),
    .sram_addr   (sram_addr),
    .sram_data_o (sram_data_o),
    .sram_data_i (sram_data_i),
    .sram_data_oe(sram_data_oe),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .sram_be_n   (sram_be_n)
  );

  // Environment: asynchronous SRAM, 256 words.
  bit [31:0] sram_mem [0:255];
  assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (rst_n && !sram_ce_n && !sram_we_n && sram_data_oe) begin
      for (int b = 0; b < 4; b++) begin
        if (!sram_be_n[b]) sram_mem[sram_addr[7:0]][8*b +: 8] <= sram_data_o[8*b +: 8];
      end
    end
  end

  // Reference model state and scoreboard.
  bit [31:0] ref_mem [0:255];

  typedef struct {
    bit          is_rd;
    logic [31:0] rdata;
    int          lat;
    int          we_cyc;
    int          oe_cyc;
    logic [19:0] addr;
    logic [3:0]  be_n;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  // Transaction-level model: latency and strobe counts from the access rules.
  task automatic model_push(input bit rd, input bit wr, input logic [31:0] a,
                            input logic [3:0] m, input logic [31:0] wd);
    exp_t e;
    int   w;
    w      = int'(a[9:2]);
    e.addr = a[21:2];
    e.be_n = ~m;
    e.wdata = wd;
    if (wr) begin
      e.is_rd  = 1'b0;
      e.lat    = W + 4;
      e.we_cyc = W + 1;
      e.oe_cyc = 0;
      e.rdata  = '0;
      for (int b = 0; b < 4; b++) if (m[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
    end else begin
      e.is_rd  = rd;
      e.lat    = W + 2;
      e.we_cyc = 0;
      e.oe_cyc = W + 1;
      e.rdata  = ref_mem[w];
    end
    exp_q.push_back(e);
  endtask

  // Monitor: tracks each bus transaction and compares on stall low.
  initial begin
    bit          open = 1'b0;
    int          start = 0, we_cnt = 0, oe_cnt = 0, viol = 0;
    logic [19:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd;
    logic [31:0] last_rd = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        open    = 1'b0;
        last_rd = '0;
      end else begin
        if (!open && (bus_read || bus_write)) begin
          open   = 1'b1;
          start  = cyc;
          we_cnt = 0;
          oe_cnt = 0;
          viol   = 0;
          s_addr = 'x;
          s_be   = 'x;
          s_wd   = 'x;
        end
        if (open) begin
          if (!sram_we_n) begin
            we_cnt++;
            s_wd = sram_data_o;
          end
          if (!sram_oe_n) oe_cnt++;
          if (!sram_ce_n) begin
            s_addr = sram_addr;
            s_be   = sram_be_n;
          end
          if ((!sram_we_n && !sram_oe_n) || (sram_data_oe && !sram_oe_n)) viol++;
          if (!bus_stall) begin
            open = 1'b0;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_completion: got completion at cycle %0d, required none", cyc);
            end else begin
              e = exp_q.pop_front();
              check("latency", 32'(cyc - start), 32'(e.lat));
              check("we_low_cycles", 32'(we_cnt), 32'(e.we_cyc));
              check("oe_low_cycles", 32'(oe_cnt), 32'(e.oe_cyc));
              check("sram_addr", 32'(s_addr), 32'(e.addr));
              check("sram_be_n", 32'(s_be), 32'(e.be_n));
              check("pin_conflict", 32'(viol), 32'd0);
              if (e.is_rd) begin
                check("rdata", bus_rdata, e.rdata);
                last_rd = e.rdata;
              end else begin
                check("sram_data_o", s_wd, e.wdata);
                check("rdata_hold", bus_rdata, last_rd);
              end
            end
          end
        end
      end
    end
  end

  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus_stall && t < 64);
    if (bus_stall) begin
      n_cmp++;
      n_fail++;
      $display("FAIL stall_timeout: stall=1 after %0d cycles, required 0", t);
      summary();
      $finish;
    end
  endtask

  // Presents one request and holds it for n back-to-back acceptances.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] wd, input int n);
    for (int k = 0; k < n; k++) model_push(rd, wr, a, m, wd);
    @(posedge clk);
    #1;
    bus_read    = rd;
    bus_write   = wr;
    bus_address = a;
    bus_mask    = m;
    bus_wdata   = wd;
    for (int k = 0; k < n; k++) wait_done();
    @(posedge clk);
    #1;
    bus_read  = 1'b0;
    bus_write = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, a, hi, wd_r, lo, m_r;
    int          op, n, t;
    rst_n       = 1'b0;
    bus_read    = 1'b0;
    bus_write   = 1'b0;
    bus_address = '0;
    bus_mask    = '0;
    bus_wdata   = '0;
    for (int i = 0; i < 256; i++) begin
      v           = $urandom;
      sram_mem[i] = v;
      ref_mem[i]  = v;
    end
    sram_mem[16] = 32'hDEADBEEF;
    ref_mem[16]  = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_stall", 32'(bus_stall), 32'd0);
    check("reset_ce_n", 32'(sram_ce_n), 32'd1);
    check("reset_oe_n", 32'(sram_oe_n), 32'd1);
    check("reset_we_n", 32'(sram_we_n), 32'd1);
    check("reset_be_n", 32'(sram_be_n), 32'hF);
    check("reset_data_oe", 32'(sram_data_oe), 32'd0);
    check("reset_rdata", bus_rdata, 32'd0);
    check("reset_sram_addr", 32'(sram_addr), 32'd0);

    issue(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0, 1);
    issue(1'b0, 1'b1, 32'h0000_0044, 4'b0011, 32'h1234_5678, 1);
    issue(1'b1, 1'b0, 32'h0000_0044, 4'hF, 32'h0, 1);
    issue(1'b1, 1'b1, 32'h0000_0008, 4'hF, 32'hA5C3_0F1E, 2);
    issue(1'b1, 1'b0, 32'h0000_0008, 4'hF, 32'h0, 1);

    // Reset during the write pulse; word 255 is kept out of every other access.
    @(posedge clk);
    #1;
    bus_write   = 1'b1;
    bus_address = 32'h0000_03FC;
    bus_mask    = 4'hF;
    bus_wdata   = $urandom;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (sram_we_n && t < 32);
    check("reached_wpulse", 32'(sram_we_n), 32'd0);
    #2;
    rst_n     = 1'b0;
    bus_write = 1'b0;
    #1;
    check("async_rst_we_n", 32'(sram_we_n), 32'd1);
    check("async_rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("async_rst_data_oe", 32'(sram_data_oe), 32'd0);
    check("async_rst_be_n", 32'(sram_be_n), 32'hF);
    check("async_rst_stall", 32'(bus_stall), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_stall", 32'(bus_stall), 32'd0);
    issue(1'b1, 1'b0, 32'h0000_0040, 4'hF, 32'h0, 1);

    for (int i = 0; i < 150; i++) begin
      op   = int'($urandom_range(0, 9));
      v    = $urandom_range(0, 254);
      hi   = $urandom_range(0, 1023);
      lo   = $urandom_range(0, 3);
      m_r  = $urandom_range(0, 15);
      wd_r = $urandom;
      a    = {hi[9:0], 12'd0, v[7:0], lo[1:0]};
      n    = ($urandom_range(0, 7) == 0) ? 2 : 1;
      issue(op < 5 || op == 9, op >= 5, a, m_r[3:0], wd_r, n);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
